// File: rtl/signed_threshold_monitor.sv
`default_nettype none
// ============================================================================
//  Module      : signed_threshold_monitor
//  Description : Multi-channel signed threshold monitor. Each channel is
//                compared against a shared programmable threshold using
//                hysteresis and consecutive-sample debounce. Produces a live
//                alarm, a sticky alarm history and a running signed peak
//                across all channels.
//  Revision    : 1.0  initial release
// ============================================================================
module signed_threshold_monitor #(
  parameter int BITS     = 8,
  parameter int CHANNELS = 2,
  parameter int DEBOUNCE = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       sample_valid,
  input  logic [CHANNELS*(BITS+1)-1:0] samples,
  input  logic                       cfg_load,
  input  logic [BITS:0]              threshold,
  input  logic [BITS-1:0]            hysteresis,
  input  logic                       sticky_clr,
  output logic [CHANNELS-1:0]        alarm,
  output logic                       alarm_any,
  output logic [CHANNELS-1:0]        alarm_sticky,
  output logic [BITS:0]              peak,
  output logic [((CHANNELS > 1) ? $clog2(CHANNELS) : 1)-1:0] peak_chan
);

  // Sample width, extended compare width, channel index width, counter width
  localparam int W    = BITS + 1;
  localparam int XW   = BITS + 2;
  localparam int CHW  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int CNTW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE + 1) : 1;

  // Most negative and most positive representable sample values
  localparam logic [W-1:0] SAMPLE_MIN = {1'b1, {BITS{1'b0}}};
  localparam logic [W-1:0] SAMPLE_MAX = {1'b0, {BITS{1'b1}}};

  localparam logic [CNTW-1:0] CNT_ZERO = '0;
  localparam logic [CNTW-1:0] CNT_ONE  = CNTW'(1);
  localparam logic [CNTW-1:0] CNT_DEB  = CNTW'(DEBOUNCE);

  // Per-channel debounce FSM encoding
  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_ARMING    = 2'd1;
  localparam logic [1:0] ST_ALARM     = 2'd2;
  localparam logic [1:0] ST_RELEASING = 2'd3;

  // --------------------------------------------------------------------------
  // Configuration shadows
  // --------------------------------------------------------------------------
  logic [W-1:0]    thr_shadow;
  logic [BITS-1:0] hyst_shadow;

  // Capture threshold/hysteresis; the new pair takes effect the cycle after
  always_ff @(posedge clk) begin
    if (rst) begin
      thr_shadow  <= SAMPLE_MAX;
      hyst_shadow <= '0;
    end else if (cfg_load) begin
      thr_shadow  <= threshold;
      hyst_shadow <= hysteresis;
    end
  end

  // Trip and release levels in one extra bit of headroom: thr - hyst spans
  // at most -2^BITS - (2^BITS - 1), which still fits in BITS+2 signed.
  logic signed [XW-1:0] thr_ext;
  logic signed [XW-1:0] rel_ext;

  assign thr_ext = $signed({thr_shadow[W-1], thr_shadow});
  assign rel_ext = thr_ext - $signed({2'b00, hyst_shadow});

  // --------------------------------------------------------------------------
  // Per-channel compare and debounce
  // --------------------------------------------------------------------------
  logic [CHANNELS-1:0] alarm_nxt;

  generate
    for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
      logic [W-1:0]         smp;
      logic signed [XW-1:0] smp_ext;
      logic                 above;
      logic                 below;
      logic [1:0]           state;
      logic [1:0]           state_nxt;
      logic [CNTW-1:0]      cnt;
      logic [CNTW-1:0]      cnt_nxt;
      logic [CNTW-1:0]      cnt_inc;

      assign smp     = samples[i*W +: W];
      assign smp_ext = $signed({smp[W-1], smp});
      assign above   = (smp_ext >  thr_ext);
      assign below   = (smp_ext <= rel_ext);
      assign cnt_inc = cnt + CNT_ONE;

      // Debounce transitions; only valid samples move the FSM or counter
      always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        if (sample_valid) begin
          case (state)
            ST_IDLE: begin
              if (above) begin
                if (DEBOUNCE == 1) begin
                  state_nxt = ST_ALARM;
                  cnt_nxt   = CNT_ZERO;
                end else begin
                  state_nxt = ST_ARMING;
                  cnt_nxt   = CNT_ONE;
                end
              end
            end
            ST_ARMING: begin
              if (above) begin
                if (cnt_inc == CNT_DEB) begin
                  state_nxt = ST_ALARM;
                  cnt_nxt   = CNT_ZERO;
                end else begin
                  cnt_nxt = cnt_inc;
                end
              end else begin
                state_nxt = ST_IDLE;
                cnt_nxt   = CNT_ZERO;
              end
            end
            ST_ALARM: begin
              if (below) begin
                if (DEBOUNCE == 1) begin
                  state_nxt = ST_IDLE;
                  cnt_nxt   = CNT_ZERO;
                end else begin
                  state_nxt = ST_RELEASING;
                  cnt_nxt   = CNT_ONE;
                end
              end
            end
            ST_RELEASING: begin
              if (below) begin
                if (cnt_inc == CNT_DEB) begin
                  state_nxt = ST_IDLE;
                  cnt_nxt   = CNT_ZERO;
                end else begin
                  cnt_nxt = cnt_inc;
                end
              end else begin
                state_nxt = ST_ALARM;
                cnt_nxt   = CNT_ZERO;
              end
            end
            default: begin
              state_nxt = ST_IDLE;
              cnt_nxt   = CNT_ZERO;
            end
          endcase
        end
      end

      // Hold FSM state and debounce count; reset drops any partial run
      always_ff @(posedge clk) begin
        if (rst) begin
          state <= ST_IDLE;
          cnt   <= CNT_ZERO;
        end else begin
          state <= state_nxt;
          cnt   <= cnt_nxt;
        end
      end

      // Alarm is asserted through both the alarm and the release-debounce phases
      assign alarm_nxt[i] = (state_nxt == ST_ALARM) || (state_nxt == ST_RELEASING);
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Alarm outputs
  // --------------------------------------------------------------------------
  logic [CHANNELS-1:0] alarm_rise;

  assign alarm_rise = alarm_nxt & ~alarm;

  // Live alarm, its OR, and the sticky history; a rise beats a same-cycle clear
  always_ff @(posedge clk) begin
    if (rst) begin
      alarm        <= '0;
      alarm_any    <= 1'b0;
      alarm_sticky <= '0;
    end else begin
      alarm        <= alarm_nxt;
      alarm_any    <= |alarm_nxt;
      alarm_sticky <= (alarm_sticky & ~{CHANNELS{sticky_clr}}) | alarm_rise;
    end
  end

  // --------------------------------------------------------------------------
  // Running peak across channels
  // --------------------------------------------------------------------------
  logic [W-1:0]   max_val;
  logic [CHW-1:0] max_idx;

  // Largest sample this cycle; strict compare keeps the lowest index on ties
  always_comb begin
    max_val = samples[W-1:0];
    max_idx = '0;
    for (int c = 1; c < CHANNELS; c++) begin
      if ($signed(samples[c*W +: W]) > $signed(max_val)) begin
        max_val = samples[c*W +: W];
        max_idx = CHW'(c);
      end
    end
  end

  // Track the peak; a clear restarts from the floor so a same-cycle sample loads
  always_ff @(posedge clk) begin
    if (rst) begin
      peak      <= SAMPLE_MIN;
      peak_chan <= '0;
    end else if (sample_valid && (sticky_clr || ($signed(max_val) > $signed(peak)))) begin
      peak      <= max_val;
      peak_chan <= max_idx;
    end else if (sticky_clr) begin
      peak      <= SAMPLE_MIN;
      peak_chan <= '0;
    end
  end

endmodule
`default_nettype wire
